keypad_scanner: RTL and testbench

- Scans the 4x4 matrix keypad and debounces the result.
- Drives the 3-bit row/col coordinate pair that the game controller compares against the mole position.
- Drives active-low column strobes, samples the active-low row returns, and reports one debounced key with press/valid flags.
- Runs on the system clock; scan rate comes from an internal prescaler.

---
 rtl/keypad_scanner_pkg.sv | 32 +++
 rtl/keypad_scanner_scan_tick_gen.sv | 41 ++++
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// ---------------------------------------------------------------------------
// keypad_scanner_pkg
// Shared constants, FSM state encoding and the row-priority helper used by
// the 4x4 keypad scanner and its prescaler.
// ---------------------------------------------------------------------------
package keypad_scanner_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Coordinate value reported on row/col while no key is held.
    localparam logic [2:0] NO_KEY = 3'd6;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } scan_state_t;

    // Lowest row index whose active-low return is pulled down. Scanning from
    // the top index downwards lets the lowest index win when several rows
    // in the strobed column are pressed together.
    function automatic logic [1:0] hit_row(input logic [ROWS-1:0] r);
        logic [1:0] h;
        h = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r[i]) h = 2'(i);
        end
        return h;
    endfunction

endpackage : keypad_scanner_pkg

// File: rtl/keypad_scanner_scan_tick_gen.sv
// ---------------------------------------------------------------------------
// scan_tick_gen
// Prescaler producing the column-dwell tick for the keypad scanner.
// The counter runs 0..SCAN_DIV-1 and wraps; tick is high for the single
// clk cycle in which the count equals SCAN_DIV-1.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (counter returns to 0)
//   tick  out  one-clk scan strobe, once every SCAN_DIV clocks
// ---------------------------------------------------------------------------
module scan_tick_gen
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : scan_tick_gen

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column per scan tick, debounces
// the hit and reports a single key as a row/col coordinate pair together
// with a level valid flag and a one-clk press pulse.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   key_row_in   in   [3:0] row returns, active-low, asynchronous to clk
//   key_col_out  out  [3:0] column strobes, active-low one-hot
//   row          out  [2:0] debounced row 0..3, NO_KEY when idle
//   col          out  [2:0] debounced column 0..3, NO_KEY when idle
//   key_valid    out  high while a debounced key is held
//   key_pulse    out  one-clk pulse when a new press is accepted
// ---------------------------------------------------------------------------
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int CNT_W        = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] key_row_in,
    output logic [COLS-1:0] key_col_out,
    output logic [2:0]      row,
    output logic [2:0]      col,
    output logic            key_valid,
    output logic            key_pulse
);

    // Debounce/release counters only ever reach DEBOUNCE_CNT-1 before the
    // transition fires, so comparing against DB_LAST equals "cnt+1 == N".
    localparam int              DB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

    logic tick;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ---------------- row return synchronizer ----------------
    logic [ROWS-1:0] sync_q1;
    logic [ROWS-1:0] r_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '1;
            r_s     <= '1;
        end else begin
            sync_q1 <= key_row_in;
            r_s     <= sync_q1;
        end
    end

    // ---------------- scan FSM ----------------
    scan_state_t     state_q,    state_d;
    logic [1:0]      col_idx_q,  col_idx_d;
    logic [1:0]      cand_row_q, cand_row_d;
    logic [1:0]      cand_col_q, cand_col_d;
    logic [DB_W-1:0] deb_cnt_q,  deb_cnt_d;
    logic [DB_W-1:0] rel_cnt_q,  rel_cnt_d;
    logic [2:0]      row_d, col_d;
    logic            valid_d, pulse_d;

    logic       key_seen;
    logic [1:0] hit;

    assign key_seen    = (r_s != 4'hF);
    assign hit         = hit_row(r_s);
    assign key_col_out = ~(4'b0001 << col_idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            cand_row_q <= 2'd0;
            cand_col_q <= 2'd0;
            deb_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            row        <= NO_KEY;
            col        <= NO_KEY;
            key_valid  <= 1'b0;
            key_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            deb_cnt_q  <= deb_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            row        <= row_d;
            col        <= col_d;
            key_valid  <= valid_d;
            key_pulse  <= pulse_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a hold/default value up front
        // so no path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        deb_cnt_d  = deb_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        row_d      = row;
        col_d      = col;
        valid_d    = key_valid;
        pulse_d    = 1'b0;

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!key_seen) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (DEBOUNCE_CNT == 1) begin
                        // A single consistent tick is enough: accept at once.
                        row_d     = {1'b0, hit};
                        col_d     = {1'b0, col_idx_q};
                        valid_d   = 1'b1;
                        pulse_d   = 1'b1;
                        rel_cnt_d = '0;
                        state_d   = PRESSED;
                    end else begin
                        cand_row_d = hit;
                        cand_col_d = col_idx_q;
                        deb_cnt_d  = DB_W'(1);
                        state_d    = DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
                    if (key_seen && (hit == cand_row_q)) begin
                        if (deb_cnt_q == DB_LAST) begin
                            row_d     = {1'b0, cand_row_q};
                            col_d     = {1'b0, cand_col_q};
                            valid_d   = 1'b1;
                            pulse_d   = 1'b1;
                            deb_cnt_d = '0;
                            rel_cnt_d = '0;
                            state_d   = PRESSED;
                        end else begin
                            deb_cnt_d = deb_cnt_q + 1'b1;
                        end
                    end else begin
                        // Contact lost or moved to another row: abandon the
                        // candidate and carry on scanning from the next column.
                        deb_cnt_d = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end

                PRESSED: begin
                    // Any closure in the held column, even a different row,
                    // counts as "still held" and restarts the release count.
                    if (!key_seen) begin
                        if (rel_cnt_q == DB_LAST) begin
                            row_d     = NO_KEY;
                            col_d     = NO_KEY;
                            valid_d   = 1'b0;
                            rel_cnt_d = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + 1'b1;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end

                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

endmodule : keypad_scanner

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// A keypad model pulls a row low whenever a pressed key sits in the column
// currently strobed. Outputs are sampled 1 time unit after the falling edge
// that follows a scan tick edge.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] key_row_in;
    logic [3:0] key_col_out;
    logic [2:0] row;
    logic [2:0] col;
    logic       key_valid;
    logic       key_pulse;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .CNT_W        (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_row_in  (key_row_in),
        .key_col_out (key_col_out),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_pulse   (key_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed keys, bit r*4+c.
    logic [15:0] keys;

    always_comb begin
        key_row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !key_col_out[c]) key_row_in[r] = 1'b0;
            end
        end
    end

    // Bench-side phase counter: with a 4-clk scan period, the edge on which
    // ph wraps 3->0 is a scan tick edge.
    int ph;
    always @(posedge clk or posedge rst) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 3) ? 0 : ph + 1;
    end

    // Pulse monitor.
    int   pulse_cnt = 0;
    int   dbl_cnt   = 0;
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (key_pulse === 1'b1) pulse_cnt++;
        if (key_pulse === 1'b1 && prev_pulse === 1'b1) dbl_cnt++;
        prev_pulse = key_pulse;
    end

    logic [11:0] obs;
    assign obs = {key_col_out, row, col, key_valid, key_pulse};

    int total = 0;
    int bad   = 0;

    function automatic logic [11:0] pk(input logic [3:0] c_out, input logic [2:0] r,
                                       input logic [2:0] k, input logic v, input logic p);
        return {c_out, r, k, v, p};
    endfunction

    task automatic next_tick();
        @(negedge clk);
        while (ph != 0) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] seq [4];
        seq = '{pk(4'b1101, 6, 6, 0, 0), pk(4'b1011, 6, 6, 0, 0),
                pk(4'b0111, 6, 6, 0, 0), pk(4'b1110, 6, 6, 0, 0)};
        keys = '0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (obs !== pk(4'b1110, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs, pk(4'b1110, 6, 6, 0, 0));
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_tick();
            total++;
            if (obs !== seq[i]) begin
                bad++;
                $display("FAIL idle_scan[%0d]: got %h want %h", i, obs, seq[i]);
            end
        end
        total++;
        if (pulse_cnt !== 0) begin
            bad++;
            $display("FAIL idle_no_pulse: got %0d want 0", pulse_cnt);
        end
    endtask

    task automatic test_press_release();
        logic [11:0] pe [4];
        logic [11:0] re [3];
        int p0;
        pe = '{pk(4'b1101, 6, 6, 0, 0), pk(4'b1101, 6, 6, 0, 0),
               pk(4'b1101, 6, 6, 0, 0), pk(4'b1101, 2, 1, 1, 1)};
        re = '{pk(4'b1101, 2, 1, 1, 0), pk(4'b1101, 2, 1, 1, 0),
               pk(4'b1011, 6, 6, 0, 0)};
        p0 = pulse_cnt;
        keys = 16'b1 << (2*4 + 1);
        for (int i = 0; i < 4; i++) begin
            next_tick();
            total++;
            if (obs !== pe[i]) begin
                bad++;
                $display("FAIL press21[%0d]: got %h want %h", i, obs, pe[i]);
            end
        end
        @(negedge clk); #1;
        total++;
        if (obs !== pk(4'b1101, 2, 1, 1, 0)) begin
            bad++;
            $display("FAIL press21_pulse_end: got %h want %h", obs, pk(4'b1101, 2, 1, 1, 0));
        end
        next_tick();
        next_tick();
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++;
            $display("FAIL press21_pulse_count: got %0d want 1", pulse_cnt - p0);
        end
        keys = '0;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            total++;
            if (obs !== re[i]) begin
                bad++;
                $display("FAIL release21[%0d]: got %h want %h", i, obs, re[i]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] be [9];
        int p0;
        be = '{pk(4'b0111, 6, 6, 0, 0), pk(4'b0111, 6, 6, 0, 0),
               pk(4'b1110, 6, 6, 0, 0), pk(4'b1101, 6, 6, 0, 0),
               pk(4'b1011, 6, 6, 0, 0), pk(4'b0111, 6, 6, 0, 0),
               pk(4'b0111, 6, 6, 0, 0), pk(4'b0111, 6, 6, 0, 0),
               pk(4'b0111, 0, 3, 1, 1)};
        p0 = pulse_cnt;
        keys = 16'b1 << 3;
        for (int i = 0; i < 9; i++) begin
            next_tick();
            if (i == 1) keys = '0;
            if (i == 2) keys = 16'b1 << 3;
            total++;
            if (obs !== be[i]) begin
                bad++;
                $display("FAIL bounce03[%0d]: got %h want %h", i, obs, be[i]);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++;
            $display("FAIL bounce03_pulse_count: got %0d want 1", pulse_cnt - p0);
        end
        keys = '0;
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b1110, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL bounce03_release: got %h want %h", obs, pk(4'b1110, 6, 6, 0, 0));
        end
    endtask

    task automatic test_multi_row();
        keys = (16'b1 << (1*4 + 0)) | (16'b1 << (3*4 + 0));
        repeat (2) next_tick();
        total++;
        if (obs !== pk(4'b1110, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL multi_debounce: got %h want %h", obs, pk(4'b1110, 6, 6, 0, 0));
        end
        next_tick();
        total++;
        if (obs !== pk(4'b1110, 1, 0, 1, 1)) begin
            bad++;
            $display("FAIL multi_accept: got %h want %h", obs, pk(4'b1110, 1, 0, 1, 1));
        end
        keys = '0;
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b1101, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL multi_release: got %h want %h", obs, pk(4'b1101, 6, 6, 0, 0));
        end
    endtask

    task automatic test_hold_glitch();
        int p0;
        int errs;
        p0   = pulse_cnt;
        errs = 0;
        keys = 16'b1 << 1;
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b1101, 0, 1, 1, 1)) begin
            bad++;
            $display("FAIL hold01_accept: got %h want %h", obs, pk(4'b1101, 0, 1, 1, 1));
        end
        for (int i = 0; i < 50; i++) begin
            if (i == 20) keys = '0;
            if (i == 21) keys = 16'b1 << 1;
            next_tick();
            total++;
            if (obs !== pk(4'b1101, 0, 1, 1, 0)) begin
                bad++;
                $display("FAIL hold01[%0d]: got %h want %h", i, obs, pk(4'b1101, 0, 1, 1, 0));
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++;
            $display("FAIL hold01_pulse_count: got %0d want 1", pulse_cnt - p0);
        end
        keys = '0;
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b1011, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL hold01_release: got %h want %h", obs, pk(4'b1011, 6, 6, 0, 0));
        end
    endtask

    task automatic test_reset_pressed();
        logic [11:0] ae [5];
        int p0;
        ae = '{pk(4'b1101, 6, 6, 0, 0), pk(4'b1011, 6, 6, 0, 0),
               pk(4'b1011, 6, 6, 0, 0), pk(4'b1011, 6, 6, 0, 0),
               pk(4'b1011, 3, 2, 1, 1)};
        keys = 16'b1 << (3*4 + 2);
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b1011, 3, 2, 1, 1)) begin
            bad++;
            $display("FAIL rst32_accept: got %h want %h", obs, pk(4'b1011, 3, 2, 1, 1));
        end
        p0 = pulse_cnt;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs !== pk(4'b1110, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL rst32_cleared: got %h want %h", obs, pk(4'b1110, 6, 6, 0, 0));
        end
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_tick();
            total++;
            if (obs !== ae[i]) begin
                bad++;
                $display("FAIL rst32_reacquire[%0d]: got %h want %h", i, obs, ae[i]);
            end
        end
        total++;
        if (pulse_cnt - p0 !== 1) begin
            bad++;
            $display("FAIL rst32_pulse_count: got %0d want 1", pulse_cnt - p0);
        end
        keys = '0;
        repeat (3) next_tick();
        total++;
        if (obs !== pk(4'b0111, 6, 6, 0, 0)) begin
            bad++;
            $display("FAIL rst32_release: got %h want %h", obs, pk(4'b0111, 6, 6, 0, 0));
        end
    endtask

    task automatic test_pulse_width();
        total++;
        if (dbl_cnt !== 0) begin
            bad++;
            $display("FAIL pulse_width: got %0d back-to-back pulses want 0", dbl_cnt);
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_multi_row();
        test_hold_glitch();
        test_reset_pressed();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_keypad_scanner
